alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Round-robin sequencer that lets two requesters share one multi-cycle ALU,
// with a single operation in flight and a held response until it is consumed.
module alu_sequencer #(
  parameter int ALU_LAT        = 1,
  parameter int ILLEGAL_OP_MSB = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req0_imm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [15:0] req1_imm,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [15:0] alu_imm,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshakes: a request transfers on a cycle where reqN_valid and reqN_ready
  // are both high; a response transfers where rsp_valid and rsp_ready are both
  // high. A valid source holds its payload stable until the transfer happens.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT + 1);

  state_t     state, state_nxt;
  logic       last_grant;
  logic [3:0] cnt;
  logic       gnt_any;
  logic       gnt_id;
  logic       gnt_illegal;

  always_comb begin
    gnt_any     = 1'b0;
    gnt_id      = 1'b0;
    state_nxt   = state;
    if (state == IDLE) begin
      // On a tie the requester that lost last time wins.
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_grant;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    gnt_illegal = (ILLEGAL_OP_MSB != 0) && (gnt_id ? req1_op[3] : req0_op[3]);
    req0_ready  = gnt_any && !gnt_id;
    req1_ready  = gnt_any && gnt_id;
    case (state)
      IDLE:    if (gnt_any) state_nxt = gnt_illegal ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_imm    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            rsp_id     <= gnt_id;
            last_grant <= gnt_id;
            if (gnt_illegal) begin
              // Rejected op: answer immediately and leave the ALU untouched.
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              cnt        <= '0;
            end else begin
              alu_op  <= gnt_id ? req1_op  : req0_op;
              alu_a   <= gnt_id ? req1_a   : req0_a;
              alu_b   <= gnt_id ? req1_b   : req0_b;
              alu_imm <= gnt_id ? req1_imm : req0_imm;
              cnt     <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: cycle-level reference model of arbitration and
// response timing, plus a scoreboard queue of expected responses.
module tb_alu_sequencer;

  localparam int ALU_LAT = 3;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req0_imm;
  logic [15:0] req1_a, req1_b, req1_imm;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_imm;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [15:0] rsp_result;
  logic        busy;
  logic [1:0]  state_dbg;

  alu_sequencer #(.ALU_LAT(ALU_LAT), .ILLEGAL_OP_MSB(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- ALU behavioural model ----------------
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] imm);
    case (op[2:0])
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a + imm;
      3'd6:    return a << b[3:0];
      default: return {a[7:0], a[15:8]} ^ imm ^ 16'h5a3c;
    endcase
  endfunction

  // Result becomes valid exactly ALU_LAT edges after operands settle.
  logic [15:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_op, alu_a, alu_b, alu_imm);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[ALU_LAT-1];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q[$];   // {id, err, result}
  int grant_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one operation outstanding; a legal op answers ALU_LAT+1
  // cycles after its grant cycle, an illegal op answers on the next cycle.
  bit          m_busy;
  int          m_cnt;
  bit          m_last;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b, m_imm;

  always @(negedge clk) begin
    bit          e_r0, e_r1, win;
    logic [3:0]  g_op;
    logic [15:0] g_a, g_b, g_imm;
    if (!reset_n) begin
      m_busy = 0; m_cnt = 0; m_last = 1;
      m_op = '0; m_a = '0; m_b = '0; m_imm = '0;
      exp_q.delete();
      check("rst_busy", 32'(busy), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_rsp_result", 32'(rsp_result), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_alu_op", 32'(alu_op), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_b", 32'(alu_b), 0);
      check("rst_alu_imm", 32'(alu_imm), 0);
    end else begin
      e_r0 = !m_busy && req0_valid && (!req1_valid || m_last == 1'b1);
      e_r1 = !m_busy && req1_valid && (!req0_valid || m_last == 1'b0);
      check("req0_ready", 32'(req0_ready), 32'(e_r0));
      check("req1_ready", 32'(req1_ready), 32'(e_r1));
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_cnt == 0));
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_imm", 32'(alu_imm), 32'(m_imm));
      if (req0_ready || req1_ready) grant_log.push_back(req1_ready ? 1 : 0);
      if (e_r0 || e_r1) begin
        win   = e_r1;
        g_op  = win ? req1_op  : req0_op;
        g_a   = win ? req1_a   : req0_a;
        g_b   = win ? req1_b   : req0_b;
        g_imm = win ? req1_imm : req0_imm;
        m_busy = 1;
        m_last = win;
        if (g_op[3]) begin
          exp_q.push_back({win, 1'b1, 16'h0000});
          m_cnt = 0;
        end else begin
          exp_q.push_back({win, 1'b0, alu_f(g_op, g_a, g_b, g_imm)});
          m_cnt = ALU_LAT + 1;
          m_op = g_op; m_a = g_a; m_b = g_b; m_imm = g_imm;
        end
      end else if (m_busy) begin
        if (m_cnt > 0) m_cnt--;
        else if (rsp_ready) m_busy = 0;
      end
    end
  end

  // Monitor: every presented response must match the queue head, and it
  // must keep matching across backpressure until consumed.
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d result=%0h err=%0d expected none",
                 rsp_id, rsp_result, rsp_err);
      end else begin
        check("rsp_id", 32'(rsp_id), 32'(exp_q[0][17]));
        check("rsp_err", 32'(rsp_err), 32'(exp_q[0][16]));
        check("rsp_result", 32'(rsp_result), 32'(exp_q[0][15:0]));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_imm = imm;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_imm = imm;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(8, 15));
    return 4'($urandom_range(0, 7));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    set_req0(0, 0, 0, 0, 0);
    set_req1(0, 0, 0, 0, 0);
    step(3);
    reset_n = 1'b1;

    // Tie straight after reset: grants alternate starting with requester 0.
    grant_log.delete();
    rsp_ready = 1'b1;
    set_req0(1, 4'd1, 16'd100, 16'd30, 16'd0);
    set_req1(1, 4'd4, 16'h00ff, 16'h0f0f, 16'd0);
    step(4 * (ALU_LAT + 3));
    set_req0(0, 0, 0, 0, 0);
    set_req1(0, 0, 0, 0, 0);
    step(ALU_LAT + 4);
    check("tie_grants", 32'(grant_log.size()), 4);
    if (grant_log.size() == 4) begin
      check("tie_grant0", 32'(grant_log[0]), 0);
      check("tie_grant1", 32'(grant_log[1]), 1);
      check("tie_grant2", 32'(grant_log[2]), 0);
      check("tie_grant3", 32'(grant_log[3]), 1);
    end

    // Single add: 5 + 7 = 12 from requester 0.
    set_req0(1, 4'd0, 16'd5, 16'd7, 16'd16);
    step(1);
    set_req0(0, 0, 0, 0, 0);
    step(ALU_LAT + 4);

    // Backpressure with requester 1 waiting during the held response.
    rsp_ready = 1'b0;
    set_req0(1, 4'd7, 16'd12, 16'd0, 16'h1234);
    step(1);
    set_req0(0, 0, 0, 0, 0);
    set_req1(1, 4'd2, 16'hf0f0, 16'h3c3c, 16'd0);
    step(ALU_LAT + 2 + 10);
    rsp_ready = 1'b1;
    step(1);
    set_req1(0, 0, 0, 0, 0);
    step(ALU_LAT + 4);

    // Illegal op from requester 1: rejected, ALU registers untouched.
    set_req1(1, 4'b1010, 16'hdead, 16'hbeef, 16'h0001);
    step(1);
    set_req1(0, 0, 0, 0, 0);
    step(3);

    // Reset one cycle into the wait: the response must never appear.
    set_req0(1, 4'd5, 16'd40, 16'd0, 16'd2);
    step(1);
    set_req0(0, 0, 0, 0, 0);
    step(1);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(ALU_LAT + 5);
    grant_log.delete();
    set_req0(1, 4'd3, 16'h0101, 16'h1010, 16'd0);
    set_req1(1, 4'd3, 16'h0202, 16'h2020, 16'd0);
    step(1);
    set_req0(0, 0, 0, 0, 0);
    set_req1(0, 0, 0, 0, 0);
    step(ALU_LAT + 4);
    check("post_reset_tie", grant_log.size() > 0 ? 32'(grant_log[0]) : 32'hffff_ffff, 0);

    // Randomized traffic: valids, operands and rsp_ready all change freely.
    for (int c = 0; c < 3000; c++) begin
      set_req0($urandom_range(0, 2) != 0, rand_op(), 16'($urandom), 16'($urandom), 16'($urandom));
      set_req1($urandom_range(0, 2) != 0, rand_op(), 16'($urandom), 16'($urandom), 16'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end

    // Drain: every granted operation must have produced its response.
    set_req0(0, 0, 0, 0, 0);
    set_req1(0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    step(ALU_LAT + 6);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
